// File: rtl/phold_pkg.sv
// Shared PHOLD definitions: MC command encodings, MC field widths, rtnctl layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package phold_pkg;

  localparam int MC_CMD_W  = 3;
  localparam int MC_SCMD_W = 4;
  localparam int MC_SIZE_W = 2;
  localparam int MC_VADR_W = 48;
  localparam int MC_DATA_W = 64;

  // rtnctl layout: tag at the bottom, core id directly above it (offset = TAG_W),
  // everything above the core id is zero.
  localparam int RTNCTL_TAG_LSB = 0;

  typedef enum logic [MC_CMD_W-1:0] {
    MC_CMD_RD   = 3'd1,
    MC_CMD_WR   = 3'd2,
    MC_CMD_RD64 = 3'd3,
    MC_CMD_WR64 = 3'd4
  } mc_cmd_e;

  // Offset of the core-id field inside rtnctl for a given tag width.
  function automatic int rtnctl_id_lsb(input int tag_w);
    return RTNCTL_TAG_LSB + tag_w;
  endfunction

  // True when two or more bits of v are set (x & (x-1) clears the lowest one).
  function automatic logic multi_hot(input logic [15:0] v);
    return (v & (v - 16'd1)) != 16'd0;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin priority select: first requester at or above ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller gates the grant and advances ptr.
module rr_arbiter #(
  parameter int N     = 8,
  parameter int PTR_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic             gnt_any,
  output logic [PTR_W-1:0] gnt_idx
);

  logic [PTR_W-1:0] idx;

  // Scan from ptr upward; N is a power of two so PTR_W-bit addition wraps for free.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      idx = ptr + PTR_W'(i);
      if (!gnt_any && req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
    gnt[gnt_idx] = gnt_any;
  end

endmodule

// File: rtl/mc_port_arbiter.sv
// Shares one MC port among NUM_CORES cores: RR request arbitration, rtnctl-tagged response routing.
// Latency: grant same cycle, mc_rq 1 cycle later; response to core 1 cycle after mc_rs_vld.
// Backpressure: mc_rq_stall blocks new grants (registered request still issues); mc_rs_stall = registered OR of core stalls.
module mc_port_arbiter
  import phold_pkg::*;
#(
  parameter int NUM_CORES    = 8,
  parameter int CORE_ID_W    = 3,
  parameter int TAG_W        = 8,
  parameter int RTNCTL_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              i_reset,
  input  logic [NUM_CORES-1:0]              core_rq_vld,
  input  logic [MC_CMD_W*NUM_CORES-1:0]     core_rq_cmd,
  input  logic [MC_SCMD_W*NUM_CORES-1:0]    core_rq_scmd,
  input  logic [MC_SIZE_W*NUM_CORES-1:0]    core_rq_size,
  input  logic [MC_VADR_W*NUM_CORES-1:0]    core_rq_vadr,
  input  logic [MC_DATA_W*NUM_CORES-1:0]    core_rq_data,
  input  logic [TAG_W*NUM_CORES-1:0]        core_rq_tag,
  output logic [NUM_CORES-1:0]              core_rq_gnt,
  output logic [NUM_CORES-1:0]              core_rs_vld,
  output logic [MC_CMD_W-1:0]               core_rs_cmd,
  output logic [MC_SCMD_W-1:0]              core_rs_scmd,
  output logic [MC_DATA_W-1:0]              core_rs_data,
  output logic [TAG_W-1:0]                  core_rs_tag,
  input  logic [NUM_CORES-1:0]              core_rs_stall,
  output logic                              mc_rq_vld,
  output logic [MC_CMD_W-1:0]               mc_rq_cmd,
  output logic [MC_SCMD_W-1:0]              mc_rq_scmd,
  output logic [MC_SIZE_W-1:0]              mc_rq_size,
  output logic [MC_VADR_W-1:0]              mc_rq_vadr,
  output logic [MC_DATA_W-1:0]              mc_rq_data,
  output logic [RTNCTL_WIDTH-1:0]           mc_rq_rtnctl,
  input  logic                              mc_rq_stall,
  input  logic                              mc_rs_vld,
  input  logic [MC_CMD_W-1:0]               mc_rs_cmd,
  input  logic [MC_SCMD_W-1:0]              mc_rs_scmd,
  input  logic [MC_DATA_W-1:0]              mc_rs_data,
  input  logic [RTNCTL_WIDTH-1:0]           mc_rs_rtnctl,
  output logic                              mc_rs_stall,
  output logic [31:0]                       arb_conflicts
);

  localparam int ID_LSB = rtnctl_id_lsb(TAG_W);

  logic [CORE_ID_W-1:0]    ptr_q, ptr_d;
  logic                    rq_vld_q, rq_vld_d;
  logic [MC_CMD_W-1:0]     rq_cmd_q, rq_cmd_d;
  logic [MC_SCMD_W-1:0]    rq_scmd_q, rq_scmd_d;
  logic [MC_SIZE_W-1:0]    rq_size_q, rq_size_d;
  logic [MC_VADR_W-1:0]    rq_vadr_q, rq_vadr_d;
  logic [MC_DATA_W-1:0]    rq_data_q, rq_data_d;
  logic [RTNCTL_WIDTH-1:0] rq_rtnctl_q, rq_rtnctl_d;
  logic [NUM_CORES-1:0]    rs_vld_q, rs_vld_d;
  logic [MC_CMD_W-1:0]     rs_cmd_q, rs_cmd_d;
  logic [MC_SCMD_W-1:0]    rs_scmd_q, rs_scmd_d;
  logic [MC_DATA_W-1:0]    rs_data_q, rs_data_d;
  logic [TAG_W-1:0]        rs_tag_q, rs_tag_d;
  logic                    rs_stall_q, rs_stall_d;
  logic [31:0]             conflicts_q, conflicts_d;

  logic [NUM_CORES-1:0]    arb_gnt;
  logic                    arb_any;
  logic [CORE_ID_W-1:0]    win_idx;
  logic                    grant_en;
  logic                    grant;
  logic [CORE_ID_W-1:0]    rs_id;
  logic                    unused_rtnctl;

  rr_arbiter #(
    .N     (NUM_CORES),
    .PTR_W (CORE_ID_W)
  ) u_rr (
    .req     (core_rq_vld),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_any (arb_any),
    .gnt_idx (win_idx)
  );

  // Grant only when the MC can take a new request and we are not in reset.
  assign grant_en    = !mc_rq_stall && !i_reset;
  assign grant       = grant_en && arb_any;
  assign core_rq_gnt = grant_en ? arb_gnt : '0;

  assign rs_id         = mc_rs_rtnctl[ID_LSB +: CORE_ID_W];
  assign unused_rtnctl = ^mc_rs_rtnctl;

  // Request path: capture the winner's fields and tag rtnctl with its core id.
  always_comb begin
    ptr_d       = ptr_q;
    rq_vld_d    = grant;
    rq_cmd_d    = rq_cmd_q;
    rq_scmd_d   = rq_scmd_q;
    rq_size_d   = rq_size_q;
    rq_vadr_d   = rq_vadr_q;
    rq_data_d   = rq_data_q;
    rq_rtnctl_d = rq_rtnctl_q;
    if (grant) begin
      ptr_d       = win_idx + CORE_ID_W'(1);
      rq_cmd_d    = core_rq_cmd[int'(win_idx)*MC_CMD_W +: MC_CMD_W];
      rq_scmd_d   = core_rq_scmd[int'(win_idx)*MC_SCMD_W +: MC_SCMD_W];
      rq_size_d   = core_rq_size[int'(win_idx)*MC_SIZE_W +: MC_SIZE_W];
      rq_vadr_d   = core_rq_vadr[int'(win_idx)*MC_VADR_W +: MC_VADR_W];
      rq_data_d   = core_rq_data[int'(win_idx)*MC_DATA_W +: MC_DATA_W];
      rq_rtnctl_d = '0;
      rq_rtnctl_d[RTNCTL_TAG_LSB +: TAG_W] = core_rq_tag[int'(win_idx)*TAG_W +: TAG_W];
      rq_rtnctl_d[ID_LSB +: CORE_ID_W]     = win_idx;
    end
  end

  // Response path: decode the core id from rtnctl into a one-hot valid; payload is broadcast.
  always_comb begin
    rs_vld_d        = '0;
    rs_vld_d[rs_id] = mc_rs_vld;
    rs_cmd_d        = rs_cmd_q;
    rs_scmd_d       = rs_scmd_q;
    rs_data_d       = rs_data_q;
    rs_tag_d        = rs_tag_q;
    if (mc_rs_vld) begin
      rs_cmd_d  = mc_rs_cmd;
      rs_scmd_d = mc_rs_scmd;
      rs_data_d = mc_rs_data;
      rs_tag_d  = mc_rs_rtnctl[RTNCTL_TAG_LSB +: TAG_W];
    end
    // Cores absorb the skid of responses already in flight, so a plain registered OR suffices.
    rs_stall_d = |core_rs_stall;
  end

  // Saturating count of cycles with two or more cores requesting, independent of stall.
  always_comb begin
    conflicts_d = conflicts_q;
    if (multi_hot(16'(core_rq_vld)) && conflicts_q != 32'hFFFF_FFFF) begin
      conflicts_d = conflicts_q + 32'd1;
    end
  end

  // State update; reset drops any registered request or response.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      ptr_q       <= '0;
      rq_vld_q    <= 1'b0;
      rq_cmd_q    <= '0;
      rq_scmd_q   <= '0;
      rq_size_q   <= '0;
      rq_vadr_q   <= '0;
      rq_data_q   <= '0;
      rq_rtnctl_q <= '0;
      rs_vld_q    <= '0;
      rs_cmd_q    <= '0;
      rs_scmd_q   <= '0;
      rs_data_q   <= '0;
      rs_tag_q    <= '0;
      rs_stall_q  <= 1'b0;
      conflicts_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rq_vld_q    <= rq_vld_d;
      rq_cmd_q    <= rq_cmd_d;
      rq_scmd_q   <= rq_scmd_d;
      rq_size_q   <= rq_size_d;
      rq_vadr_q   <= rq_vadr_d;
      rq_data_q   <= rq_data_d;
      rq_rtnctl_q <= rq_rtnctl_d;
      rs_vld_q    <= rs_vld_d;
      rs_cmd_q    <= rs_cmd_d;
      rs_scmd_q   <= rs_scmd_d;
      rs_data_q   <= rs_data_d;
      rs_tag_q    <= rs_tag_d;
      rs_stall_q  <= rs_stall_d;
      conflicts_q <= conflicts_d;
    end
  end

  assign mc_rq_vld     = rq_vld_q;
  assign mc_rq_cmd     = rq_cmd_q;
  assign mc_rq_scmd    = rq_scmd_q;
  assign mc_rq_size    = rq_size_q;
  assign mc_rq_vadr    = rq_vadr_q;
  assign mc_rq_data    = rq_data_q;
  assign mc_rq_rtnctl  = rq_rtnctl_q;
  assign core_rs_vld   = rs_vld_q;
  assign core_rs_cmd   = rs_cmd_q;
  assign core_rs_scmd  = rs_scmd_q;
  assign core_rs_data  = rs_data_q;
  assign core_rs_tag   = rs_tag_q;
  assign mc_rs_stall   = rs_stall_q;
  assign arb_conflicts = conflicts_q;

endmodule

// File: tb/tb_mc_port_arbiter.sv
// Self-checking bench for mc_port_arbiter: directed scenarios plus randomized traffic.
// Latency: expectations derived from a cycle-level reference model of the arbitration rules.
// Backpressure: random mc_rq_stall and core_rs_stall exercised in the random phase.
module tb_mc_port_arbiter;

  localparam int N     = 8;
  localparam int IDW   = 3;
  localparam int TAG_W = 8;
  localparam int RW    = 32;

  logic              clk = 1'b0;
  logic              i_reset;
  logic [N-1:0]      core_rq_vld;
  logic [3*N-1:0]    core_rq_cmd;
  logic [4*N-1:0]    core_rq_scmd;
  logic [2*N-1:0]    core_rq_size;
  logic [48*N-1:0]   core_rq_vadr;
  logic [64*N-1:0]   core_rq_data;
  logic [TAG_W*N-1:0] core_rq_tag;
  logic [N-1:0]      core_rq_gnt;
  logic [N-1:0]      core_rs_vld;
  logic [2:0]        core_rs_cmd;
  logic [3:0]        core_rs_scmd;
  logic [63:0]       core_rs_data;
  logic [TAG_W-1:0]  core_rs_tag;
  logic [N-1:0]      core_rs_stall;
  logic              mc_rq_vld;
  logic [2:0]        mc_rq_cmd;
  logic [3:0]        mc_rq_scmd;
  logic [1:0]        mc_rq_size;
  logic [47:0]       mc_rq_vadr;
  logic [63:0]       mc_rq_data;
  logic [RW-1:0]     mc_rq_rtnctl;
  logic              mc_rq_stall;
  logic              mc_rs_vld;
  logic [2:0]        mc_rs_cmd;
  logic [3:0]        mc_rs_scmd;
  logic [63:0]       mc_rs_data;
  logic [RW-1:0]     mc_rs_rtnctl;
  logic              mc_rs_stall;
  logic [31:0]       arb_conflicts;

  mc_port_arbiter #(
    .NUM_CORES(N), .CORE_ID_W(IDW), .TAG_W(TAG_W), .RTNCTL_WIDTH(RW)
  ) dut (
    .clk(clk), .i_reset(i_reset),
    .core_rq_vld(core_rq_vld), .core_rq_cmd(core_rq_cmd), .core_rq_scmd(core_rq_scmd),
    .core_rq_size(core_rq_size), .core_rq_vadr(core_rq_vadr), .core_rq_data(core_rq_data),
    .core_rq_tag(core_rq_tag), .core_rq_gnt(core_rq_gnt),
    .core_rs_vld(core_rs_vld), .core_rs_cmd(core_rs_cmd), .core_rs_scmd(core_rs_scmd),
    .core_rs_data(core_rs_data), .core_rs_tag(core_rs_tag), .core_rs_stall(core_rs_stall),
    .mc_rq_vld(mc_rq_vld), .mc_rq_cmd(mc_rq_cmd), .mc_rq_scmd(mc_rq_scmd),
    .mc_rq_size(mc_rq_size), .mc_rq_vadr(mc_rq_vadr), .mc_rq_data(mc_rq_data),
    .mc_rq_rtnctl(mc_rq_rtnctl), .mc_rq_stall(mc_rq_stall),
    .mc_rs_vld(mc_rs_vld), .mc_rs_cmd(mc_rs_cmd), .mc_rs_scmd(mc_rs_scmd),
    .mc_rs_data(mc_rs_data), .mc_rs_rtnctl(mc_rs_rtnctl), .mc_rs_stall(mc_rs_stall),
    .arb_conflicts(arb_conflicts)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state and expected outputs for the cycle just clocked.
  int            m_ptr;
  logic [31:0]   m_conf;
  logic [N-1:0]  exp_gnt;
  logic          exp_mc_vld;
  logic [152:0]  exp_rq;     // {cmd, scmd, size, vadr, data, rtnctl}
  logic [N-1:0]  exp_rs_vld;
  logic [78:0]   exp_rs;     // {cmd, scmd, data, tag}
  logic          exp_mc_rs_stall;
  logic [N-1:0]  obs_gnt;
  int            wait_cnt [N];

  // Spec rules in plain arithmetic: search upward from ptr mod N, tag rtnctl = id*2^TAG_W + tag.
  task automatic model_eval();
    int win;
    int c;
    win = -1;
    if (!i_reset && !mc_rq_stall) begin
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (win < 0 && core_rq_vld[c]) win = c;
      end
    end
    exp_gnt = '0;
    if (win >= 0) exp_gnt[win] = 1'b1;
    if (i_reset) begin
      m_ptr = 0; m_conf = '0; exp_mc_vld = 1'b0; exp_rq = '0;
      exp_rs_vld = '0; exp_rs = '0; exp_mc_rs_stall = 1'b0;
    end else begin
      exp_mc_vld = (win >= 0);
      if (win >= 0) begin
        m_ptr  = (win + 1) % N;
        exp_rq = {core_rq_cmd[win*3 +: 3], core_rq_scmd[win*4 +: 4], core_rq_size[win*2 +: 2],
                  core_rq_vadr[win*48 +: 48], core_rq_data[win*64 +: 64],
                  RW'(win * (1 << TAG_W)) + RW'(core_rq_tag[win*TAG_W +: TAG_W])};
      end
      if ($countones(core_rq_vld) >= 2 && m_conf != 32'hFFFF_FFFF) m_conf = m_conf + 32'd1;
      exp_rs_vld = '0;
      if (mc_rs_vld) begin
        exp_rs_vld[(mc_rs_rtnctl / (1 << TAG_W)) % N] = 1'b1;
        exp_rs = {mc_rs_cmd, mc_rs_scmd, mc_rs_data, mc_rs_rtnctl[TAG_W-1:0]};
      end
      exp_mc_rs_stall = (core_rs_stall != '0);
    end
  endtask

  // One clock: sample grant and evaluate the model mid-cycle, then land just after the edge.
  task automatic tick();
    @(negedge clk);
    obs_gnt = core_rq_gnt;
    model_eval();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input int i, input logic [TAG_W-1:0] tag, input logic [47:0] vadr);
    core_rq_cmd[i*3 +: 3]       = 3'($urandom_range(1, 4));
    core_rq_scmd[i*4 +: 4]      = 4'($urandom);
    core_rq_size[i*2 +: 2]      = 2'($urandom);
    core_rq_vadr[i*48 +: 48]    = vadr;
    core_rq_data[i*64 +: 64]    = {$urandom, $urandom};
    core_rq_tag[i*TAG_W +: TAG_W] = tag;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    core_rq_vld = '1;
    mc_rs_vld = 1'b1;
    mc_rs_rtnctl = 32'h0000_0512;
    core_rs_stall = '1;
    for (int i = 0; i < N; i++) set_core(i, 8'($urandom), {16'h0, $urandom});
    tick();
    tick();
    n_cmp++; if (obs_gnt !== '0) begin n_fail++; $display("FAIL reset_gnt: got %h want 00", obs_gnt); end
    n_cmp++; if (mc_rq_vld !== 1'b0) begin n_fail++; $display("FAIL reset_mc_rq_vld: got %b want 0", mc_rq_vld); end
    n_cmp++; if (core_rs_vld !== '0) begin n_fail++; $display("FAIL reset_core_rs_vld: got %h want 00", core_rs_vld); end
    n_cmp++; if (arb_conflicts !== 32'd0) begin n_fail++; $display("FAIL reset_conflicts: got %0d want 0", arb_conflicts); end
    n_cmp++; if ({mc_rq_cmd, mc_rq_vadr, mc_rq_data, mc_rq_rtnctl, core_rs_data, core_rs_tag, mc_rs_stall} !== '0) begin
      n_fail++; $display("FAIL reset_data_zero: rtnctl %h vadr %h rs_data %h rs_stall %b, want all 0",
                         mc_rq_rtnctl, mc_rq_vadr, core_rs_data, mc_rs_stall);
    end
    i_reset = 1'b0; core_rq_vld = '0; mc_rs_vld = 1'b0; mc_rs_rtnctl = '0; core_rs_stall = '0;
  endtask

  task automatic test_single();
    set_core(3, 8'h5A, 48'h1000);
    core_rq_vld = 8'h08;
    tick();
    core_rq_vld = '0;
    n_cmp++; if (obs_gnt !== 8'h08) begin n_fail++; $display("FAIL single_gnt: got %h want 08", obs_gnt); end
    n_cmp++; if (mc_rq_vld !== 1'b1) begin n_fail++; $display("FAIL single_mc_rq_vld: got %b want 1", mc_rq_vld); end
    n_cmp++; if (mc_rq_vadr !== 48'h1000) begin n_fail++; $display("FAIL single_vadr: got %h want 1000", mc_rq_vadr); end
    n_cmp++; if (mc_rq_rtnctl !== 32'h35A) begin n_fail++; $display("FAIL single_rtnctl: got %h want 35a", mc_rq_rtnctl); end
    n_cmp++; if ({mc_rq_cmd, mc_rq_scmd, mc_rq_size, mc_rq_vadr, mc_rq_data, mc_rq_rtnctl} !== exp_rq) begin
      n_fail++; $display("FAIL single_fields: got data %h want %h", mc_rq_data, exp_rq[95:32]);
    end
    tick();
    n_cmp++; if (mc_rq_vld !== 1'b0) begin n_fail++; $display("FAIL single_one_cycle: mc_rq_vld got %b want 0", mc_rq_vld); end
  endtask

  task automatic test_rotate();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    core_rq_vld = '1;
    for (int c = 0; c < 16; c++) begin
      for (int i = 0; i < N; i++) set_core(i, 8'($urandom), {16'h0, $urandom});
      tick();
      n_cmp++; if (obs_gnt !== 8'(1 << (c % N))) begin n_fail++; $display("FAIL rotate_gnt[%0d]: got %h want %h", c, obs_gnt, 8'(1 << (c % N))); end
      n_cmp++; if (mc_rq_rtnctl !== exp_rq[31:0] || mc_rq_vld !== 1'b1) begin
        n_fail++; $display("FAIL rotate_issue[%0d]: got vld %b rtnctl %h want 1 %h", c, mc_rq_vld, mc_rq_rtnctl, exp_rq[31:0]);
      end
    end
    n_cmp++; if (arb_conflicts !== 32'd16) begin n_fail++; $display("FAIL rotate_conflicts: got %0d want 16", arb_conflicts); end
    core_rq_vld = '0;
  endtask

  task automatic test_stall();
    core_rq_vld = 8'h06;
    mc_rq_stall = 1'b1;
    #1;
    n_cmp++; if (mc_rq_vld !== 1'b1) begin n_fail++; $display("FAIL stall_skid: mc_rq_vld got %b want 1", mc_rq_vld); end
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++; if (obs_gnt !== '0) begin n_fail++; $display("FAIL stall_gnt[%0d]: got %h want 00", c, obs_gnt); end
    end
    mc_rq_stall = 1'b0;
    tick();
    n_cmp++; if (obs_gnt !== 8'h02) begin n_fail++; $display("FAIL stall_release_first: got %h want 02", obs_gnt); end
    core_rq_vld = 8'h04;
    tick();
    n_cmp++; if (obs_gnt !== 8'h04) begin n_fail++; $display("FAIL stall_release_second: got %h want 04", obs_gnt); end
    n_cmp++; if (arb_conflicts !== 32'd22) begin n_fail++; $display("FAIL stall_conflicts: got %0d want 22", arb_conflicts); end
    core_rq_vld = '0;
  endtask

  task automatic test_rsp_route();
    mc_rs_vld = 1'b1; mc_rs_rtnctl = 32'h6C3; mc_rs_data = 64'hDEADBEEF;
    mc_rs_cmd = 3'd2; mc_rs_scmd = 4'd5;
    tick();
    mc_rs_vld = 1'b0;
    n_cmp++; if (core_rs_vld !== 8'h40) begin n_fail++; $display("FAIL route_vld: got %h want 40", core_rs_vld); end
    n_cmp++; if (core_rs_tag !== 8'hC3) begin n_fail++; $display("FAIL route_tag: got %h want c3", core_rs_tag); end
    n_cmp++; if (core_rs_data !== 64'hDEADBEEF) begin n_fail++; $display("FAIL route_data: got %h want deadbeef", core_rs_data); end
    n_cmp++; if ({core_rs_cmd, core_rs_scmd} !== 7'h25) begin n_fail++; $display("FAIL route_cmd: got %h want 25", {core_rs_cmd, core_rs_scmd}); end
    tick();
    n_cmp++; if (core_rs_vld !== '0) begin n_fail++; $display("FAIL route_one_cycle: got %h want 00", core_rs_vld); end
  endtask

  task automatic test_rsp_backpressure();
    core_rs_stall = 8'h10;
    tick();
    n_cmp++; if (mc_rs_stall !== 1'b1) begin n_fail++; $display("FAIL bp_assert: got %b want 1", mc_rs_stall); end
    core_rs_stall = '0;
    tick();
    n_cmp++; if (mc_rs_stall !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %b want 0", mc_rs_stall); end
  endtask

  task automatic test_random();
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 400; c++) begin
      mc_rq_stall   = ($urandom_range(0, 3) == 0);
      core_rs_stall = 8'($urandom) & 8'($urandom);
      mc_rs_vld     = $urandom_range(0, 1) == 1;
      mc_rs_cmd     = 3'($urandom); mc_rs_scmd = 4'($urandom);
      mc_rs_data    = {$urandom, $urandom};
      mc_rs_rtnctl  = RW'($urandom_range(0, N - 1) * (1 << TAG_W)) + RW'($urandom_range(0, 255));
      tick();
      n_cmp++; if (obs_gnt !== exp_gnt) begin n_fail++; $display("FAIL rand_gnt[%0d]: got %h want %h", c, obs_gnt, exp_gnt); end
      n_cmp++; if (mc_rq_vld !== exp_mc_vld || {mc_rq_cmd, mc_rq_scmd, mc_rq_size, mc_rq_vadr, mc_rq_data, mc_rq_rtnctl} !== exp_rq) begin
        n_fail++; $display("FAIL rand_mc_rq[%0d]: got vld %b rtnctl %h vadr %h want %b %h %h",
                           c, mc_rq_vld, mc_rq_rtnctl, mc_rq_vadr, exp_mc_vld, exp_rq[31:0], exp_rq[143:96]);
      end
      n_cmp++; if (core_rs_vld !== exp_rs_vld || {core_rs_cmd, core_rs_scmd, core_rs_data, core_rs_tag} !== exp_rs) begin
        n_fail++; $display("FAIL rand_rs[%0d]: got vld %h tag %h want %h %h", c, core_rs_vld, core_rs_tag, exp_rs_vld, exp_rs[7:0]);
      end
      n_cmp++; if (mc_rs_stall !== exp_mc_rs_stall || arb_conflicts !== m_conf) begin
        n_fail++; $display("FAIL rand_stall_conf[%0d]: got %b %0d want %b %0d", c, mc_rs_stall, arb_conflicts, exp_mc_rs_stall, m_conf);
      end
      // Fairness: count grants to others while pending; then advance each core's request.
      for (int i = 0; i < N; i++) begin
        if (obs_gnt[i]) begin
          n_cmp++; if (wait_cnt[i] > N - 1) begin n_fail++; $display("FAIL rand_fair core %0d: waited %0d want <= %0d", i, wait_cnt[i], N - 1); end
          wait_cnt[i] = 0;
          core_rq_vld[i] = $urandom_range(0, 1) == 1;
          if (core_rq_vld[i]) set_core(i, 8'($urandom), {$urandom, 16'($urandom)});
        end else if (core_rq_vld[i]) begin
          if (obs_gnt != '0) wait_cnt[i]++;
        end else if ($urandom_range(0, 4) < 2) begin
          core_rq_vld[i] = 1'b1;
          set_core(i, 8'($urandom), {$urandom, 16'($urandom)});
        end
      end
    end
    mc_rq_stall = 1'b0; core_rs_stall = '0; mc_rs_vld = 1'b0; core_rq_vld = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    core_rq_vld = 8'h24;
    set_core(2, 8'h11, 48'h2222);
    set_core(5, 8'h55, 48'h5555);
    tick();
    n_cmp++; if (mc_rq_vld !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_vld: got %b want 1", mc_rq_vld); end
    i_reset = 1'b1;
    tick();
    n_cmp++; if (obs_gnt !== '0) begin n_fail++; $display("FAIL midrst_gnt: got %h want 00", obs_gnt); end
    n_cmp++; if (mc_rq_vld !== 1'b0) begin n_fail++; $display("FAIL midrst_mc_rq_vld: got %b want 0", mc_rq_vld); end
    n_cmp++; if (arb_conflicts !== 32'd0) begin n_fail++; $display("FAIL midrst_conflicts: got %0d want 0", arb_conflicts); end
    i_reset = 1'b0;
    tick();
    n_cmp++; if (obs_gnt !== 8'h04) begin n_fail++; $display("FAIL midrst_first_gnt: got %h want 04", obs_gnt); end
    n_cmp++; if (mc_rq_rtnctl !== 32'h211) begin n_fail++; $display("FAIL midrst_rtnctl: got %h want 211", mc_rq_rtnctl); end
    core_rq_vld = '0;
  endtask

  initial begin
    i_reset = 1'b1;
    core_rq_vld = '0; core_rq_cmd = '0; core_rq_scmd = '0; core_rq_size = '0;
    core_rq_vadr = '0; core_rq_data = '0; core_rq_tag = '0; core_rs_stall = '0;
    mc_rq_stall = 1'b0; mc_rs_vld = 1'b0; mc_rs_cmd = '0; mc_rs_scmd = '0;
    mc_rs_data = '0; mc_rs_rtnctl = '0;
    m_ptr = 0; m_conf = '0;
    test_reset();
    test_single();
    test_rotate();
    test_stall();
    test_rsp_route();
    test_rsp_backpressure();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_port_arbiter.md
Name: mc_port_arbiter

Overview:
- Shares one memory-controller (MC) request/response port among NUM_CORES PHOLD event-processing cores.
- Round-robin arbitration on requests. Core ID is tagged into rtnctl; responses are routed back to the issuing core by that tag.
- Sits between the per-core memory engines inside phold and one MC port slice, so more cores than MC ports can be instantiated.
- Also counts arbitration-conflict cycles for the run report.

Parameters:
- NUM_CORES, 8: number of requesting cores. Power of 2, range 2..16.
- CORE_ID_W, 3: log2(NUM_CORES).
- TAG_W, 8: per-core request tag width, returned unchanged with the response.
- RTNCTL_WIDTH, 32: MC rtnctl width. Must be at least TAG_W+CORE_ID_W.

Ports:
- clk  in  1  core clock
- i_reset  in  1  reset, synchronous, active-high
- core_rq_vld  in  NUM_CORES  per-core request valid; held until granted
- core_rq_cmd  in  3*NUM_CORES  MC command per core
- core_rq_scmd  in  4*NUM_CORES  MC sub-command per core
- core_rq_size  in  2*NUM_CORES  access size per core
- core_rq_vadr  in  48*NUM_CORES  virtual address per core
- core_rq_data  in  64*NUM_CORES  write data per core
- core_rq_tag  in  TAG_W*NUM_CORES  per-core tag
- core_rq_gnt  out  NUM_CORES  one-hot grant, combinational, same cycle as acceptance
- core_rs_vld  out  NUM_CORES  one-hot response valid
- core_rs_cmd  out  3  response command, broadcast to all cores
- core_rs_scmd  out  4  response sub-command, broadcast
- core_rs_data  out  64  response data, broadcast
- core_rs_tag  out  TAG_W  returned tag, broadcast
- core_rs_stall  in  NUM_CORES  per-core response backpressure
- mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_size, mc_rq_vadr, mc_rq_data  out  1/3/4/2/48/64  MC request
- mc_rq_rtnctl  out  RTNCTL_WIDTH  {zero pad, core_id, tag}
- mc_rq_stall  in  1  MC request backpressure
- mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_data, mc_rs_rtnctl  in  1/3/4/64/RTNCTL_WIDTH  MC response
- mc_rs_stall  out  1  response backpressure to MC
- arb_conflicts  out  32  cycles with more than one requester pending

Behaviour:
- Reset (synchronous):
  - mc_rq_vld, core_rs_vld and core_rq_gnt are 0; all data outputs are 0.
  - RR pointer is 0; arb_conflicts is 0.
  - Reset asserted mid-operation drops any registered request or response. Cores must reissue.
- Grant:
  - Allowed in cycle t only when mc_rq_stall=0 and !i_reset.
  - Winner is the first core with core_rq_vld=1 searching from the RR pointer upward, wrapping modulo NUM_CORES.
  - core_rq_gnt[winner]=1 in cycle t; the core deasserts or advances its request at t+1.
- Pointer: advances to winner+1 (wrapping NUM_CORES-1 to 0) only on a grant; otherwise it holds.
- Request issue:
  - The winner's fields are registered. mc_rq_vld=1 for exactly one cycle at t+1, which gives 1-cycle latency.
  - mc_rq_rtnctl[TAG_W-1:0] carries the tag; [TAG_W+CORE_ID_W-1:TAG_W] carries the winner ID; upper bits are 0.
- Request throughput and fairness:
  - At most one request per cycle.
  - With all cores continuously requesting and no stall, grants rotate 0,1,…,N-1,0.
  - A continuously requesting core waits at most NUM_CORES-1 grants.
- Stall: mc_rq_stall=1 blocks new grants. An already-registered mc_rq_vld still issues, because MC stall tolerates skid.
- Response routing:
  - On mc_rs_vld=1, the response is registered. At the next cycle core_rs_vld has bit [id] set, where id = rtnctl[TAG_W+CORE_ID_W-1:TAG_W].
  - core_rs_tag = rtnctl[TAG_W-1:0]; cmd, scmd and data pass through unchanged. Latency is 1 cycle.
- Response backpressure:
  - mc_rs_stall = registered OR of core_rs_stall.
  - Every core tolerates up to 2 responses arriving after it asserts stall.
- Simultaneous request grant and response delivery in the same cycle are independent paths; no interaction.
- Conflict counter:
  - arb_conflicts increments by 1 each cycle in which popcount(core_rq_vld) ≥ 2, regardless of stall.
  - It saturates at 0xFFFF_FFFF.
- Write flush is not handled here; flush passes around this block.

Decomposition:
- Shared package phold_pkg:
  - MC command encodings (RD, WR, RD64, WR64).
  - Constants MC_VADR_W=48, MC_DATA_W=64, and the rtnctl field-offset constants.
- Sub-module rr_arbiter: parameterised N-way round-robin priority select.
  - Inputs: req[N], pointer. Output: one-hot gnt.
  - Used here and reusable for the event-queue scheduler.

Test Plan:
- Single requester: core 3 requests with tag 0x5A, vadr 0x1000 → gnt[3] same cycle; next cycle mc_rq_vld=1, vadr 0x1000, rtnctl=0x35A.
- All 8 cores hold vld for 16 cycles, no stall → grant order 0..7,0..7; arb_conflicts=16.
- Request stall: mc_rq_stall=1 for 5 cycles with cores 1 and 2 requesting → no gnt; then gnt[1] first, gnt[2] next cycle.
- Response routing: mc_rs_vld with rtnctl=0x6C3, data=0xDEADBEEF → next cycle core_rs_vld=0x40, tag=0xC3, data=0xDEADBEEF.
- Response backpressure: core_rs_stall[4]=1 → mc_rs_stall=1 next cycle, and drops 1 cycle after release.
- Reset mid-traffic: assert i_reset with a request registered → mc_rq_vld=0 the next cycle; pointer 0; arb_conflicts=0; after reset the first grant goes to the lowest-index requester.
